// File: rtl/vproc_vreg_wr_arbiter.sv
// Vector register file write-port arbiter: round-robin among execution units with
// burst lock until a last beat, followed by an optional registered output stage.
module vproc_vreg_wr_arbiter #(
    parameter int unsigned REQ_CNT = 5,
    parameter int unsigned VREG_W  = 128,
    parameter bit          BUF_WR  = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        async_rst_i,
    input  logic [REQ_CNT-1:0]          req_valid_i,
    output logic [REQ_CNT-1:0]          req_ready_o,
    input  logic [REQ_CNT-1:0]          req_last_i,
    input  logic [REQ_CNT*5-1:0]        req_addr_i,
    input  logic [REQ_CNT*VREG_W-1:0]   req_data_i,
    input  logic [REQ_CNT*VREG_W/8-1:0] req_be_i,
    output logic                        wr_valid_o,
    input  logic                        wr_ready_i,
    output logic [4:0]                  wr_addr_o,
    output logic [VREG_W-1:0]           wr_data_o,
    output logic [VREG_W/8-1:0]         wr_be_o,
    output logic [REQ_CNT-1:0]          grant_o
);

    localparam int unsigned BE_W  = VREG_W / 8;
    localparam int unsigned IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e           state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [4:0]        addr_arr [REQ_CNT];
    logic [VREG_W-1:0] data_arr [REQ_CNT];
    logic [BE_W-1:0]   be_arr   [REQ_CNT];

    logic [SUM_W-1:0]   cand_sum [REQ_CNT];
    logic [IDX_W-1:0]   cand_idx [REQ_CNT];
    logic [REQ_CNT-1:0] cand_valid;

    logic [IDX_W-1:0] scan_idx;
    logic             scan_hit;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_active;
    logic             sel_valid;
    logic             out_free;
    logic             accept;

    // Candidate gi is the unit gi positions after the round-robin pointer.
    generate
        for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_i[5*gi +: 5];
            assign data_arr[gi] = req_data_i[VREG_W*gi +: VREG_W];
            assign be_arr[gi]   = req_be_i[BE_W*gi +: BE_W];

            assign cand_sum[gi]   = {1'b0, rr_ptr_reg} + SUM_W'(gi);
            assign cand_idx[gi]   = (cand_sum[gi] >= SUM_W'(REQ_CNT))
                                  ? IDX_W'(cand_sum[gi] - SUM_W'(REQ_CNT))
                                  : cand_sum[gi][IDX_W-1:0];
            assign cand_valid[gi] = req_valid_i[cand_idx[gi]];
        end
    endgenerate

    // Walk from the far end so the candidate closest to the pointer wins.
    always_comb begin
        scan_idx = '0;
        scan_hit = 1'b0;
        for (int k = REQ_CNT - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        sel_idx     = scan_idx;
        sel_active  = scan_hit;
        if (state_reg == ST_LOCKED) begin
            sel_idx    = owner_reg;
            sel_active = 1'b1;
        end
        sel_valid = sel_active && req_valid_i[sel_idx];
        accept    = sel_valid && out_free;
        if (accept) begin
            if (req_last_i[sel_idx]) begin
                state_next  = ST_IDLE;
                rr_ptr_next = (sel_idx == IDX_W'(REQ_CNT - 1)) ? '0 : sel_idx + IDX_W'(1);
            end else begin
                state_next = ST_LOCKED;
                owner_next = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // The owner sees ready even while its own valid is low (lock hold).
    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        if (!async_rst_i && sel_active) begin
            req_ready_o[sel_idx] = out_free;
            grant_o[sel_idx]     = 1'b1;
        end
    end

    generate
        if (BUF_WR) begin : g_buf
            logic              wr_valid_reg;
            logic [4:0]        wr_addr_reg;
            logic [VREG_W-1:0] wr_data_reg;
            logic [BE_W-1:0]   wr_be_reg;

            assign out_free = !wr_valid_reg || wr_ready_i;

            always_ff @(posedge clk_i or posedge async_rst_i) begin
                if (async_rst_i) begin
                    wr_valid_reg <= 1'b0;
                    wr_addr_reg  <= '0;
                    wr_data_reg  <= '0;
                    wr_be_reg    <= '0;
                end else if (accept) begin
                    wr_valid_reg <= 1'b1;
                    wr_addr_reg  <= addr_arr[sel_idx];
                    wr_data_reg  <= data_arr[sel_idx];
                    wr_be_reg    <= be_arr[sel_idx];
                end else if (wr_ready_i) begin
                    wr_valid_reg <= 1'b0;
                end
            end

            assign wr_valid_o = wr_valid_reg;
            assign wr_addr_o  = wr_addr_reg;
            assign wr_data_o  = wr_data_reg;
            assign wr_be_o    = wr_be_reg;

            a_hold_stable: assert property (@(posedge clk_i) disable iff (async_rst_i)
                (wr_valid_reg && !wr_ready_i) |=>
                (wr_valid_reg && $stable(wr_addr_reg) && $stable(wr_data_reg) && $stable(wr_be_reg)));
        end else begin : g_comb
            assign out_free   = wr_ready_i;
            assign wr_valid_o = sel_valid && !async_rst_i;
            assign wr_addr_o  = async_rst_i ? '0 : addr_arr[sel_idx];
            assign wr_data_o  = async_rst_i ? '0 : data_arr[sel_idx];
            assign wr_be_o    = async_rst_i ? '0 : be_arr[sel_idx];
        end
    endgenerate

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (async_rst_i)
        $onehot0(req_ready_o));
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (async_rst_i)
        $onehot0(grant_o));

endmodule
